rcn_master_queue: RTL and testbench

- Client-side front end that sits directly upstream of the rcn bus master interface.
- Buffers client requests in a FIFO and drives the master's cs/seq/wr/mask/addr/wdata. Each issued request gets a 2-bit sequence number.
- Collects rdone/wdone responses by rsp_seq into a 4-entry reorder buffer (ROB) and returns completions to the client strictly in issue order.

---
 rtl/rcn_pkg.sv | 25 ++
 rtl/rcn_sync_fifo.sv | 60 ++++++
 rtl/rcn_master_queue.sv | 165 ++++++++++++++++
 tb/tb_rcn_master_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcn_pkg.sv
// rcn_pkg
// Shared definitions for the rcn bus client front end: field widths of the
// master interface and the request bundle that travels through the request
// FIFO.
package rcn_pkg;

   localparam int RCN_ADDR_W = 22;
   localparam int RCN_DATA_W = 32;
   localparam int RCN_MASK_W = 4;
   localparam int RCN_SEQ_W  = 2;

   // Number of distinct sequence tags, and therefore reorder-buffer slots.
   localparam int RCN_NUM_TAGS = 1 << RCN_SEQ_W;

   // One queued client request: {wr, mask, addr, wdata} = 59 bits.
   typedef struct packed {
      logic                  wr;
      logic [RCN_MASK_W-1:0] mask;
      logic [RCN_ADDR_W-1:0] addr;
      logic [RCN_DATA_W-1:0] wdata;
   } rcn_req_t;

   localparam int RCN_REQ_W = $bits(rcn_req_t);

endpackage

// File: rtl/rcn_sync_fifo.sv
// rcn_sync_fifo
// Generic single-clock FIFO with registered full/empty flags and a
// show-ahead head (pop_data is valid whenever empty=0).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write request and data
//   pop               remove the head entry (ignored when empty)
//   pop_data          current head entry
//   full, empty       occupancy flags, derived only from registered pointers
module rcn_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4   // power of two, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A push while full is legal only when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // NOTE: storage has no reset; the pointers alone define which entries are
   // valid, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rcn_master_queue.sv
// rcn_master_queue
// Client-side front end for the rcn bus master. Requests are buffered in a
// FIFO and presented to the master with a 2-bit sequence tag; responses come
// back in any order, are parked in a 4-slot reorder buffer indexed by tag,
// and are handed to the client strictly in issue order.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               client request handshake
//   req_wr/mask/addr/wdata            client request fields
//   cs, seq, wr, mask, addr, wdata    request presented to the master
//   busy                              master stalls the presented request
//   rdone, wdone, rsp_seq, rsp_data   responses from the master
//   cpl_valid/cpl_ready               in-order completion handshake
//   cpl_wr, cpl_data                  completion kind and read data (0 for writes)
//   outstanding                       issued but not yet retired transactions
//   err_stray                         sticky: response for a non-pending tag
module rcn_master_queue
   import rcn_pkg::*;
#(
   parameter int DEPTH   = 4,  // request FIFO entries, power of two >= 2
   parameter int MAX_OUT = 4   // outstanding transaction limit, 1..4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [RCN_MASK_W-1:0] req_mask,
   input  logic [RCN_ADDR_W-1:0] req_addr,
   input  logic [RCN_DATA_W-1:0] req_wdata,
   output logic                  cs,
   output logic [RCN_SEQ_W-1:0]  seq,
   input  logic                  busy,
   output logic                  wr,
   output logic [RCN_MASK_W-1:0] mask,
   output logic [RCN_ADDR_W-1:0] addr,
   output logic [RCN_DATA_W-1:0] wdata,
   input  logic                  rdone,
   input  logic                  wdone,
   input  logic [RCN_SEQ_W-1:0]  rsp_seq,
   input  logic [RCN_DATA_W-1:0] rsp_data,
   output logic                  cpl_valid,
   input  logic                  cpl_ready,
   output logic                  cpl_wr,
   output logic [RCN_DATA_W-1:0] cpl_data,
   output logic [2:0]            outstanding,
   output logic                  err_stray
);

   // ---------------------------------------------------------------- FIFO
   rcn_req_t push_req;
   rcn_req_t head;
   logic     fifo_full;
   logic     fifo_empty;
   logic     xfer;

   assign push_req = '{wr: req_wr, mask: req_mask, addr: req_addr, wdata: req_wdata};

   // Ready comes from registered state only; no ready-through when full.
   assign req_ready = !fifo_full;

   rcn_sync_fifo #(
      .WIDTH (RCN_REQ_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid && req_ready),
      .push_data (push_req),
      .pop       (xfer),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ----------------------------------------------------------- ROB state
   logic [RCN_NUM_TAGS-1:0] slot_pending;
   logic [RCN_NUM_TAGS-1:0] slot_done;
   logic [RCN_NUM_TAGS-1:0] slot_wr;
   logic [RCN_DATA_W-1:0]   slot_data [RCN_NUM_TAGS];
   logic [RCN_SEQ_W-1:0]    issue_seq;
   logic [RCN_SEQ_W-1:0]    ret_seq;
   logic [2:0]              outstanding_q;
   logic                    err_q;

   // ---------------------------------------------------------------- issue
   // The pending check keeps a tag from being reused before it retires; a
   // slot freed this cycle only becomes issuable next cycle because
   // slot_pending is registered.
   assign cs    = !fifo_empty && (outstanding_q < 3'(MAX_OUT)) && !slot_pending[issue_seq];
   assign xfer  = cs && !busy;
   assign seq   = issue_seq;
   assign wr    = head.wr;
   assign mask  = head.mask;
   assign addr  = head.addr;
   assign wdata = head.wdata;

   // ------------------------------------------------------------- response
   // A response that hits the slot being retired is impossible for a legal
   // master (that slot is already done), so response and retire never
   // collide on the same slot. Simultaneous rdone+wdone is handled as a
   // read but still flagged.
   logic rsp_valid;
   logic rsp_ok;
   logic rsp_bad;

   assign rsp_valid = rdone || wdone;
   assign rsp_ok    = rsp_valid && slot_pending[rsp_seq] && !slot_done[rsp_seq];
   assign rsp_bad   = rsp_valid && (!rsp_ok || (rdone && wdone));

   // --------------------------------------------------------------- retire
   logic retire;

   assign cpl_valid = slot_done[ret_seq];
   assign cpl_wr    = cpl_valid && slot_wr[ret_seq];
   // Gate the data so stale slot contents never leak onto an idle bus.
   assign cpl_data  = cpl_valid ? slot_data[ret_seq] : '0;
   assign retire    = cpl_valid && cpl_ready;

   assign outstanding = outstanding_q;
   assign err_stray   = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_pending  <= '0;
         slot_done     <= '0;
         slot_wr       <= '0;
         issue_seq     <= '0;
         ret_seq       <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         if (retire) begin
            slot_pending[ret_seq] <= 1'b0;
            slot_done[ret_seq]    <= 1'b0;
            ret_seq               <= ret_seq + 1'b1;
         end
         if (xfer) begin
            slot_pending[issue_seq] <= 1'b1;
            slot_wr[issue_seq]      <= head.wr;
            issue_seq               <= issue_seq + 1'b1;
         end
         if (rsp_ok) begin
            slot_done[rsp_seq] <= 1'b1;
         end
         if (rsp_bad) begin
            err_q <= 1'b1;
         end
         case ({xfer, retire})
            2'b10:   outstanding_q <= outstanding_q + 3'd1;
            2'b01:   outstanding_q <= outstanding_q - 3'd1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   // Read data is only observed while the slot is done, so it needs no reset.
   always_ff @(posedge clk) begin
      if (rsp_ok) begin
         slot_data[rsp_seq] <= rdone ? rsp_data : '0;
      end
   end

endmodule

// File: tb/tb_rcn_master_queue.sv
// tb_rcn_master_queue
// Directed bench for rcn_master_queue (DEPTH=4, MAX_OUT=4). Inputs change
// 1 ns after the rising edge; outputs are checked at that point too, well
// away from the active edge.
module tb_rcn_master_queue;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [3:0]  req_mask;
   logic [21:0] req_addr;
   logic [31:0] req_wdata;
   logic        cs;
   logic [1:0]  seq;
   logic        busy;
   logic        wr;
   logic [3:0]  mask;
   logic [21:0] addr;
   logic [31:0] wdata;
   logic        rdone;
   logic        wdone;
   logic [1:0]  rsp_seq;
   logic [31:0] rsp_data;
   logic        cpl_valid;
   logic        cpl_ready;
   logic        cpl_wr;
   logic [31:0] cpl_data;
   logic [2:0]  outstanding;
   logic        err_stray;

   int n_tests = 0;
   int n_fail  = 0;

   rcn_master_queue #(
      .DEPTH   (4),
      .MAX_OUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wr      (req_wr),
      .req_mask    (req_mask),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .cs          (cs),
      .seq         (seq),
      .busy        (busy),
      .wr          (wr),
      .mask        (mask),
      .addr        (addr),
      .wdata       (wdata),
      .rdone       (rdone),
      .wdone       (wdone),
      .rsp_seq     (rsp_seq),
      .rsp_data    (rsp_data),
      .cpl_valid   (cpl_valid),
      .cpl_ready   (cpl_ready),
      .cpl_wr      (cpl_wr),
      .cpl_data    (cpl_data),
      .outstanding (outstanding),
      .err_stray   (err_stray)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic w, input logic [3:0] m,
                          input logic [21:0] a, input logic [31:0] d);
      req_valid = v;
      req_wr    = w;
      req_mask  = m;
      req_addr  = a;
      req_wdata = d;
   endtask

   // One-cycle response strobe: rd=1 drives rdone, rd=0 drives wdone.
   task automatic respond(input logic rd, input logic [1:0] tag, input logic [31:0] d);
      rdone    = rd;
      wdone    = !rd;
      rsp_seq  = tag;
      rsp_data = d;
      tick();
      rdone    = 1'b0;
      wdone    = 1'b0;
   endtask

   // Wait (bounded) for a completion, check it, then accept it.
   task automatic take_cpl(input string tag, input logic exp_wr, input logic [31:0] exp_data);
      int waited = 0;
      while (!cpl_valid && waited < 20) begin
         tick();
         waited++;
      end
      check({tag, "_valid"}, 64'(cpl_valid), 64'd1);
      if (cpl_valid) begin
         check({tag, "_wr"}, 64'(cpl_wr), 64'(exp_wr));
         check({tag, "_data"}, 64'(cpl_data), 64'(exp_data));
         cpl_ready = 1'b1;
         tick();
         cpl_ready = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int any_bad;

      rst       = 1'b1;
      busy      = 1'b0;
      rdone     = 1'b0;
      wdone     = 1'b0;
      rsp_seq   = '0;
      rsp_data  = '0;
      cpl_ready = 1'b0;
      set_req(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);

      // ---------------- reset state
      #2;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_cs", 64'(cs), 64'd0);
      check("rst_cpl_valid", 64'(cpl_valid), 64'd0);
      check("rst_cpl_wr", 64'(cpl_wr), 64'd0);
      check("rst_cpl_data", 64'(cpl_data), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err_stray", 64'(err_stray), 64'd0);
      tick();
      tick();
      rst = 1'b0;

      // ---------------- single read
      set_req(1'b1, 1'b0, 4'hF, 22'h000100, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
      check("single_cs", 64'(cs), 64'd1);
      check("single_seq", 64'(seq), 64'd0);
      check("single_addr", 64'(addr), 64'h000100);
      check("single_wr", 64'(wr), 64'd0);
      check("single_mask", 64'(mask), 64'hF);
      tick();  // transfer
      check("single_out1", 64'(outstanding), 64'd1);
      check("single_cs_idle", 64'(cs), 64'd0);
      respond(1'b1, 2'd0, 32'hDEADBEEF);
      take_cpl("single", 1'b0, 32'hDEADBEEF);
      check("single_out0", 64'(outstanding), 64'd0);

      // ---------------- backpressure (next tag is 1)
      busy = 1'b1;
      set_req(1'b1, 1'b1, 4'h3, 22'h0002A4, 32'h12345678);
      tick();
      set_req(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_cs_%0d", i), 64'(cs), 64'd1);
         check($sformatf("bp_addr_%0d", i), 64'(addr), 64'h0002A4);
         check($sformatf("bp_wdata_%0d", i), 64'(wdata), 64'h12345678);
         check($sformatf("bp_out_%0d", i), 64'(outstanding), 64'd0);
         tick();
      end
      busy = 1'b0;
      check("bp_seq", 64'(seq), 64'd1);
      tick();  // transfer on first non-busy cycle
      check("bp_out1", 64'(outstanding), 64'd1);
      check("bp_cs_idle", 64'(cs), 64'd0);
      respond(1'b0, 2'd1, 32'hFFFFFFFF);
      take_cpl("bp", 1'b1, 32'h0);
      check("bp_out0", 64'(outstanding), 64'd0);

      // ---------------- fill (next tag is 2)
      busy = 1'b1;
      check("fill_ready0", 64'(req_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         set_req(1'b1, 1'b0, 4'hF, 22'(32'h10 + 4 * k), 32'h0);
         tick();
      end
      check("fill_full_ready", 64'(req_ready), 64'd0);
      check("fill_head", 64'(addr), 64'h10);
      set_req(1'b1, 1'b0, 4'hF, 22'h20, 32'h0);
      tick();
      check("fill_5th_held", 64'(req_ready), 64'd0);
      check("fill_no_pop", 64'(outstanding), 64'd0);
      check("fill_head_hold", 64'(addr), 64'h10);
      busy = 1'b0;
      tick();  // transfer 0x10 (seq 2); 5th not yet accepted
      check("fill_space", 64'(req_ready), 64'd1);
      check("fill_out1", 64'(outstanding), 64'd1);
      check("fill_head2", 64'(addr), 64'h14);
      tick();  // accept 5th, transfer 0x14 (seq 3)
      set_req(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
      tick();  // 0x18 (seq 0)
      tick();  // 0x1C (seq 1)
      check("fill_out4", 64'(outstanding), 64'd4);
      check("fill_cs_limit", 64'(cs), 64'd0);
      check("fill_5th_head", 64'(addr), 64'h20);
      respond(1'b1, 2'd2, 32'hA0);
      take_cpl("fill_a0", 1'b0, 32'hA0);
      check("fill_reuse_cs", 64'(cs), 64'd1);
      check("fill_reuse_seq", 64'(seq), 64'd2);
      respond(1'b1, 2'd3, 32'hA4);  // 0x20 transfers on this edge as seq 2
      take_cpl("fill_a4", 1'b0, 32'hA4);
      respond(1'b1, 2'd0, 32'hA8);
      take_cpl("fill_a8", 1'b0, 32'hA8);
      respond(1'b1, 2'd1, 32'hAC);
      take_cpl("fill_ac", 1'b0, 32'hAC);
      respond(1'b1, 2'd2, 32'hB0);
      take_cpl("fill_b0", 1'b0, 32'hB0);
      check("fill_out0", 64'(outstanding), 64'd0);

      // ---------------- reorder (fresh tags from 0)
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_req(1'b1, 1'b0, 4'hF, 22'(32'h40 + 4 * k), 32'h0);
         tick();
      end
      set_req(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
      check("ro_out4", 64'(outstanding), 64'd4);
      check("ro_cs_limit", 64'(cs), 64'd0);
      respond(1'b1, 2'd3, 32'h33);
      check("ro_hold3", 64'(cpl_valid), 64'd0);
      respond(1'b1, 2'd1, 32'h11);
      check("ro_hold1", 64'(cpl_valid), 64'd0);
      respond(1'b1, 2'd2, 32'h22);
      check("ro_hold2", 64'(cpl_valid), 64'd0);
      respond(1'b1, 2'd0, 32'h00);
      take_cpl("ro_0", 1'b0, 32'h00);
      take_cpl("ro_1", 1'b0, 32'h11);
      take_cpl("ro_2", 1'b0, 32'h22);
      take_cpl("ro_3", 1'b0, 32'h33);
      check("ro_out_5th", 64'(outstanding), 64'd1);
      respond(1'b1, 2'd0, 32'h44);
      take_cpl("ro_4", 1'b0, 32'h44);
      check("ro_out0", 64'(outstanding), 64'd0);

      // ---------------- stray response
      check("stray_pre", 64'(err_stray), 64'd0);
      respond(1'b0, 2'd2, 32'h0);
      check("stray_set", 64'(err_stray), 64'd1);
      check("stray_no_cpl", 64'(cpl_valid), 64'd0);
      tick();
      tick();
      tick();
      check("stray_sticky", 64'(err_stray), 64'd1);
      check("stray_out", 64'(outstanding), 64'd0);

      // ---------------- reset mid-flight (next tags 1 and 2)
      set_req(1'b1, 1'b0, 4'hF, 22'h80, 32'h0);
      tick();
      set_req(1'b1, 1'b1, 4'hF, 22'h84, 32'h5A5A5A5A);
      tick();
      set_req(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
      tick();
      check("mid_out2", 64'(outstanding), 64'd2);
      respond(1'b1, 2'd1, 32'h55);
      check("mid_cpl_pending", 64'(cpl_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_cpl_valid", 64'(cpl_valid), 64'd0);
      check("mid_rst_cpl_data", 64'(cpl_data), 64'd0);
      check("mid_rst_cs", 64'(cs), 64'd0);
      check("mid_rst_out", 64'(outstanding), 64'd0);
      check("mid_rst_err", 64'(err_stray), 64'd0);
      check("mid_rst_ready", 64'(req_ready), 64'd1);
      tick();
      rst = 1'b0;
      cpl_ready = 1'b1;
      any_bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (cpl_valid || cs || outstanding != 3'd0) any_bad++;
         tick();
      end
      cpl_ready = 1'b0;
      check("mid_quiet_after_rst", 64'(any_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
